crtc_init_sequencer: RTL and testbench
======================================

Name: crtc_init_sequencer

Overview:
Upstream bus master for the MC6845 CRTC in the VGA top level. Drives the CRTC CPU-side interface (CSn, E, RS, RW, D) on clk:
- Out of reset, programs all 16 CRTC registers R0–R15 from an internal table.
- Afterwards, forwards single-register writes from a host request port.
- The top level ties crtc_d/crtc_d_oe onto the CRTC's D bus (tristate in top level).

Parameters:
E_HALF, 4, clk cycles per E phase (setup phase and E-high phase); legal range 1..255
AUTO_START, 1, 1 = begin table load on the first cycle after rst deasserts; 0 = wait for start
NUM_REGS, 16, table entries loaded, R0..R(NUM_REGS-1); legal range 1..16

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  pulse: (re)run table load; ignored while busy=1
busy  output  1  table load or host write in progress
done  output  1  table load has completed; level, cleared by rst or start
host_req  input  1  request single CRTC register write; hold until host_ack
host_addr  input  5  target register 0..17
host_data  input  8  value to write
host_ack  output  1  one-cycle pulse, write finished
crtc_csn  output  1  CRTC chip select, active low
crtc_e  output  1  CRTC enable strobe; CRTC latches on falling edge
crtc_rs  output  1  0 = address register, 1 = data register
crtc_rw  output  1  0 = write; this block never reads
crtc_d  output  8  write data toward CRTC D bus
crtc_d_oe  output  1  1 = top level drives D from crtc_d

Behaviour:
- Reset values (rst=1 at a clock edge, effective the next cycle): crtc_csn=1, crtc_e=0, crtc_rs=0, crtc_rw=1, crtc_d=0, crtc_d_oe=0, busy=0, done=0, host_ack=0.
- Reset mid-operation aborts the access immediately; no partial E pulse follows.
- Bus access, fixed 10 cycles:
  - SETUP: E_HALF cycles. csn=0, rw=0, d_oe=1, rs/d valid, e=0.
  - EHIGH: E_HALF cycles. e=1, all else unchanged.
  - HOLD: 1 cycle. e=0, rs/d/csn unchanged (falling edge latched here).
  - GAP: 1 cycle. csn=1, rw=1, d_oe=0, e=0.
  - Total duration is 2*E_HALF+2 cycles; 10 cycles at E_HALF=4.
- Register write = address access (rs=0, d={3'b0,addr}) followed immediately by data access (rs=1, d=value).
- FSM states: IDLE, LOAD_ADDR, LOAD_DATA, NEXT, DONE, HOST_ADDR, HOST_DATA, HOST_ACK.
  - Each *_ADDR/*_DATA state runs the SETUP/EHIGH/HOLD/GAP sub-counter.
- Table load:
  - Start condition: AUTO_START=1 and first cycle after rst, or a start pulse in IDLE/DONE.
  - Sets busy=1 and done=0, then writes index 0..NUM_REGS-1 in ascending order.
  - After the final data access GAP, enters DONE: busy=0, done=1 in the next cycle.
- Table contents, hex, R0..R15: 71 50 5A 0A 1F 06 19 1C 02 07 06 07 00 00 00 00.
- Host write:
  - Accepted only in IDLE or DONE; a host_req during a table load waits until the load completes.
  - Captures host_addr/host_data on acceptance; later changes to these inputs are ignored.
  - Runs addr+data accesses with busy=1, then host_ack=1 for exactly 1 cycle and returns to the prior IDLE/DONE state (done is unchanged).
  - host_addr>17: host_ack pulses the cycle after acceptance, no bus activity, busy stays 0.
  - The next request is accepted no earlier than the cycle after host_ack.
- Priority: start and host_req in the same cycle → start wins; host_req remains pending.
- Index counter is 4 bits; no wrap beyond NUM_REGS-1.

Optional Feature:
CRTC_HOST_PORT_EN:
- Defined: host write port operates as above.
- Undefined: host_req, host_addr and host_data are ignored; host_ack is held 0; HOST_* states are not built. Table load behaviour and timing are identical.

Test Plan:
- Reset check: hold rst 3 cycles → csn=1, e=0, rw=1, d_oe=0, busy=0, done=0, host_ack=0.
- Auto load (E_HALF=4): release rst → busy=1 from cycle 1; 32 falling E edges; pairs (rs=0,d=0x00),(rs=1,d=0x71) … (rs=0,d=0x0F),(rs=1,d=0x00); done=1 at cycle 321.
- E timing: each access shows 4 cycles e=0 with csn=0, 4 cycles e=1, 1 hold cycle with d stable, 1 cycle csn=1.
- Host write after done: req addr=0x0E, data=0x12 → bus pairs (0,0x0E),(1,0x12); host_ack single pulse; done stays 1.
- Host req during load: assert host_req at cycle 50 → no host access until the load completes, then host write; ack follows.
- Mid-load reset: assert rst at cycle 137 (during an EHIGH phase) → next cycle e=0, csn=1; after release, load restarts from R0.

Source files
------------

// File: rtl/crtc_init_sequencer.sv
// MC6845 CRTC bus master: programs R0..R(NUM_REGS-1) from a fixed table, then forwards host writes.
// Define CRTC_HOST_PORT_EN to build the host write port; otherwise host inputs are ignored.

module crtc_init_sequencer #(
   parameter int E_HALF     = 4,
   parameter bit AUTO_START = 1'b1,
   parameter int NUM_REGS   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   input  logic       host_req,
   input  logic [4:0] host_addr,
   input  logic [7:0] host_data,
   output logic       host_ack,
   output logic       crtc_csn,
   output logic       crtc_e,
   output logic       crtc_rs,
   output logic       crtc_rw,
   output logic [7:0] crtc_d,
   output logic       crtc_d_oe
);

   localparam int              PH_W      = 9;
   localparam logic [PH_W-1:0] EHIGH_CNT = PH_W'(E_HALF);
   localparam logic [PH_W-1:0] HOLD_CNT  = PH_W'(2 * E_HALF);
   localparam logic [PH_W-1:0] GAP_CNT   = PH_W'(2 * E_HALF + 1);
   localparam logic [3:0]      LAST_IDX  = 4'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_ADDR,
      LOAD_DATA,
      NEXT,
      DONE
`ifdef CRTC_HOST_PORT_EN
      ,
      HOST_ADDR,
      HOST_DATA,
      HOST_ACK
`endif
   } state_t;

   function automatic logic [7:0] table_value(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h71;
         4'd1:    return 8'h50;
         4'd2:    return 8'h5A;
         4'd3:    return 8'h0A;
         4'd4:    return 8'h1F;
         4'd5:    return 8'h06;
         4'd6:    return 8'h19;
         4'd7:    return 8'h1C;
         4'd8:    return 8'h02;
         4'd9:    return 8'h07;
         4'd10:   return 8'h06;
         4'd11:   return 8'h07;
         default: return 8'h00;
      endcase
   endfunction

   state_t          state_q, state_n;
   logic [PH_W-1:0] ph_q, ph_n;
   logic [3:0]      idx_q, idx_n;
   logic            done_q, done_n;
   logic            first_q;
   logic            begin_load;

`ifdef CRTC_HOST_PORT_EN
   logic [4:0] haddr_q;
   logic [7:0] hdata_q;
   logic       host_accept;
`else
   logic       unused_host;
   assign unused_host = ^{host_req, host_addr, host_data};
`endif

   // first_q marks the first cycle after reset so AUTO_START can launch the load once.
   assign begin_load = start | (AUTO_START & first_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ph_q    <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         first_q <= 1'b1;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_n;
         ph_q    <= ph_n;
         idx_q   <= idx_n;
         done_q  <= done_n;
         first_q <= 1'b0;
      end
   end

`ifdef CRTC_HOST_PORT_EN
   // NOTE: captured host address/data are only read in HOST_* states, so they need no reset.
   always_ff @(posedge clk) begin
      if (host_accept) begin
         haddr_q <= host_addr;
         hdata_q <= host_data;
      end
   end
`endif

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_n = state_q;
      ph_n    = ph_q;
      idx_n   = idx_q;
      done_n  = done_q;
`ifdef CRTC_HOST_PORT_EN
      host_accept = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (begin_load) begin
               state_n = LOAD_ADDR;
               ph_n    = '0;
               idx_n   = '0;
               done_n  = 1'b0;
            end
`ifdef CRTC_HOST_PORT_EN
            else if (host_req) begin
               host_accept = 1'b1;
               ph_n        = '0;
               state_n     = (host_addr > 5'd17) ? HOST_ACK : HOST_ADDR;
            end
`endif
         end
         LOAD_ADDR: begin
            ph_n = (ph_q == GAP_CNT) ? '0 : ph_q + 1'b1;
            if (ph_q == GAP_CNT) state_n = LOAD_DATA;
         end
         // The data access's GAP cycle is spent in NEXT, which also advances the index.
         LOAD_DATA: begin
            ph_n = ph_q + 1'b1;
            if (ph_q == HOLD_CNT) state_n = NEXT;
         end
         NEXT: begin
            ph_n = '0;
            if (idx_q == LAST_IDX) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               idx_n   = idx_q + 1'b1;
               state_n = LOAD_ADDR;
            end
         end
`ifdef CRTC_HOST_PORT_EN
         HOST_ADDR: begin
            ph_n = (ph_q == GAP_CNT) ? '0 : ph_q + 1'b1;
            if (ph_q == GAP_CNT) state_n = HOST_DATA;
         end
         HOST_DATA: begin
            ph_n = (ph_q == GAP_CNT) ? '0 : ph_q + 1'b1;
            if (ph_q == GAP_CNT) state_n = HOST_ACK;
         end
         HOST_ACK: begin
            if (start) begin
               state_n = LOAD_ADDR;
               ph_n    = '0;
               idx_n   = '0;
               done_n  = 1'b0;
            end else begin
               state_n = done_q ? DONE : IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = done_q;
      host_ack  = 1'b0;
      crtc_csn  = 1'b1;
      crtc_e    = 1'b0;
      crtc_rs   = 1'b0;
      crtc_rw   = 1'b1;
      crtc_d    = 8'h00;
      crtc_d_oe = 1'b0;
      case (state_q)
         LOAD_ADDR: begin
            busy   = 1'b1;
            crtc_d = {4'b0000, idx_q};
         end
         LOAD_DATA: begin
            busy    = 1'b1;
            crtc_rs = 1'b1;
            crtc_d  = table_value(idx_q);
         end
         NEXT: busy = 1'b1;
`ifdef CRTC_HOST_PORT_EN
         HOST_ADDR: begin
            busy   = 1'b1;
            crtc_d = {3'b000, haddr_q};
         end
         HOST_DATA: begin
            busy    = 1'b1;
            crtc_rs = 1'b1;
            crtc_d  = hdata_q;
         end
         HOST_ACK: host_ack = 1'b1;
`endif
         default: ;
      endcase
      // Bus strobes: SETUP/EHIGH/HOLD select the chip, GAP releases it.
      if (busy && state_q != NEXT && ph_q <= HOLD_CNT) begin
         crtc_csn  = 1'b0;
         crtc_rw   = 1'b0;
         crtc_d_oe = 1'b1;
         crtc_e    = (ph_q >= EHIGH_CNT) && (ph_q < HOLD_CNT);
      end
   end

endmodule

// File: tb/tb_crtc_init_sequencer.sv
// Self-checking bench for crtc_init_sequencer: scoreboard of expected (rs,d) pairs
// popped on each falling E edge, plus directed timing and reset checks.

module tb_crtc_init_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic       host_req;
   logic [4:0] host_addr;
   logic [7:0] host_data;
   logic       host_ack;
   logic       crtc_csn;
   logic       crtc_e;
   logic       crtc_rs;
   logic       crtc_rw;
   logic [7:0] crtc_d;
   logic       crtc_d_oe;

   int vectors     = 0;
   int miscompares = 0;

   logic [8:0] exp_q[$];
   logic [7:0] tbl[16] = '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                           8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};

   crtc_init_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .host_req  (host_req),
      .host_addr (host_addr),
      .host_data (host_data),
      .host_ack  (host_ack),
      .crtc_csn  (crtc_csn),
      .crtc_e    (crtc_e),
      .crtc_rs   (crtc_rs),
      .crtc_rw   (crtc_rw),
      .crtc_d    (crtc_d),
      .crtc_d_oe (crtc_d_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_pair(input logic [4:0] a, input logic [7:0] v);
      exp_q.push_back({1'b0, 3'b000, a});
      exp_q.push_back({1'b1, v});
   endtask

   task automatic push_table();
      for (int i = 0; i < 16; i++) push_pair(5'(i), tbl[i]);
   endtask

   // Bus monitor: times each access and pops the scoreboard on every selected E fall.
   int         setup_cnt = 0;
   int         high_cnt  = 0;
   logic       prev_e    = 1'b0;
   logic [7:0] prev_d    = 8'h00;
   logic       gap_chk   = 1'b0;
   logic [8:0] exp_pair;

   always @(negedge clk) begin
      if (rst) begin
         setup_cnt = 0;
         high_cnt  = 0;
         prev_e    = 1'b0;
         gap_chk   = 1'b0;
      end else begin
         if (gap_chk) begin
            check("gap_csn", 32'(crtc_csn), 32'd1);
            check("gap_rw", 32'(crtc_rw), 32'd1);
            check("gap_d_oe", 32'(crtc_d_oe), 32'd0);
            gap_chk = 1'b0;
         end
         if (crtc_e === 1'b0 && prev_e === 1'b1 && crtc_csn === 1'b0) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            exp_pair = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
            check("access_rs", 32'(crtc_rs), 32'(exp_pair[8]));
            check("access_d", 32'(crtc_d), 32'(exp_pair[7:0]));
            check("hold_d_stable", 32'(crtc_d), 32'(prev_d));
            check("access_rw", 32'(crtc_rw), 32'd0);
            check("access_d_oe", 32'(crtc_d_oe), 32'd1);
            check("setup_cycles", 32'(setup_cnt), 32'd4);
            check("ehigh_cycles", 32'(high_cnt), 32'd4);
            gap_chk   = 1'b1;
            setup_cnt = 0;
            high_cnt  = 0;
         end else if (crtc_csn !== 1'b0) begin
            setup_cnt = 0;
            high_cnt  = 0;
         end else if (crtc_e === 1'b1) begin
            high_cnt++;
         end else begin
            setup_cnt++;
         end
         prev_e = crtc_e;
         prev_d = crtc_d;
      end
   end

   // Runs one table load from the cycle after the launching edge; optional host request injection.
   task automatic run_load(input string tag, input int req_at, input logic [4:0] a,
                           input logic [7:0] v);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            check({tag, "_busy_c1"}, 32'(busy), 32'd1);
            check({tag, "_done_c1"}, 32'(done), 32'd0);
         end
         if (cyc == req_at) begin
            host_addr = a;
            host_data = v;
            host_req  = 1'b1;
         end
      end while (done !== 1'b1 && cyc < 400);
      check({tag, "_done_cycle"}, 32'(cyc), 32'd321);
   endtask

   task automatic wait_ack(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (host_ack !== 1'b1 && lat < 100);
      check({tag, "_ack_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_at_ack"}, 32'(busy), 32'd0);
      host_req = 1'b0;
      @(negedge clk);
      check({tag, "_ack_single"}, 32'(host_ack), 32'd0);
   endtask

   initial begin
      int cyc;
      rst       = 1'b1;
      start     = 1'b0;
      host_req  = 1'b0;
      host_addr = 5'h00;
      host_data = 8'h00;
      repeat (3) @(negedge clk);

      check("rst_csn", 32'(crtc_csn), 32'd1);
      check("rst_e", 32'(crtc_e), 32'd0);
      check("rst_rs", 32'(crtc_rs), 32'd0);
      check("rst_rw", 32'(crtc_rw), 32'd1);
      check("rst_d", 32'(crtc_d), 32'd0);
      check("rst_d_oe", 32'(crtc_d_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ack", 32'(host_ack), 32'd0);

      // Auto load out of reset, with a host request raised mid-load.
      push_table();
`ifdef CRTC_HOST_PORT_EN
      push_pair(5'h05, 8'hA5);
      rst = 1'b0;
      run_load("auto", 50, 5'h05, 8'hA5);
      wait_ack("held_req", 21);
      check("held_req_done", 32'(done), 32'd1);
`else
      rst = 1'b0;
      run_load("auto", -1, 5'h00, 8'h00);
`endif
      check("auto_sb_drain", 32'(exp_q.size()), 32'd0);

`ifdef CRTC_HOST_PORT_EN
      // Host write after done; inputs change after acceptance and must be ignored.
      push_pair(5'h0E, 8'h12);
      host_addr = 5'h0E;
      host_data = 8'h12;
      host_req  = 1'b1;
      @(negedge clk);
      check("host_busy", 32'(busy), 32'd1);
      host_addr = 5'h01;
      host_data = 8'hFF;
      wait_ack("host_e12", 20);
      check("host_done_kept", 32'(done), 32'd1);
      check("host_sb_drain", 32'(exp_q.size()), 32'd0);

      // Out-of-range address: ack next cycle, no bus activity.
      host_addr = 5'd20;
      host_data = 8'h33;
      host_req  = 1'b1;
      wait_ack("bad_addr", 1);
      check("bad_addr_csn", 32'(crtc_csn), 32'd1);
      check("bad_addr_done", 32'(done), 32'd1);
`else
      host_addr = 5'h0E;
      host_data = 8'h12;
      host_req  = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("noport_ack", 32'(host_ack), 32'd0);
         check("noport_busy", 32'(busy), 32'd0);
      end
      host_req = 1'b0;
`endif

      // Start and host_req together: start wins, request waits for the reload.
      push_table();
`ifdef CRTC_HOST_PORT_EN
      push_pair(5'h03, 8'h44);
      host_addr = 5'h03;
      host_data = 8'h44;
      host_req  = 1'b1;
      start     = 1'b1;
      run_load("restart", -1, 5'h00, 8'h00);
      wait_ack("start_prio", 21);
`else
      start = 1'b1;
      run_load("restart", -1, 5'h00, 8'h00);
`endif
      check("restart_sb_drain", 32'(exp_q.size()), 32'd0);

      // Mid-load reset during EHIGH of access 13 (R6 data); 13 accesses complete before it.
      for (int i = 0; i < 6; i++) push_pair(5'(i), tbl[i]);
      exp_q.push_back({1'b0, 8'h06});
      start = 1'b1;
      cyc   = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
      end while (cyc < 137);
      check("pre_abort_e", 32'(crtc_e), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_e", 32'(crtc_e), 32'd0);
      check("abort_csn", 32'(crtc_csn), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sb_drain", 32'(exp_q.size()), 32'd0);
      push_table();
      rst = 1'b0;
      run_load("reload", -1, 5'h00, 8'h00);
      check("reload_sb_drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
